// File: rtl/dma_regfile_pkg.sv
// Shared constants and types for the multi-channel DMA APB register file.
package dma_regfile_pkg;

  localparam int          GLOBAL_BIT = 11;
  localparam logic [11:0] CH_STRIDE  = 12'h040;

  localparam logic [5:0] OFF_CONFIG0 = 6'h00;
  localparam logic [5:0] OFF_CONFIG1 = 6'h04;
  localparam logic [5:0] OFF_CONFIG2 = 6'h08;
  localparam logic [5:0] OFF_CONFIG3 = 6'h0C;
  localparam logic [5:0] OFF_START   = 6'h20;
  localparam logic [5:0] OFF_STATUS  = 6'h30;

  localparam logic [7:0] OFF_INT_STATUS = 8'h00;
  localparam logic [7:0] OFF_INT_ENABLE = 8'h04;
  localparam logic [7:0] OFF_BUSY       = 8'h08;

  typedef enum logic [1:0] {IDLE, WAIT, READY} apb_state_t;

endpackage

// File: rtl/dma_regfile_mc_ch_regs.sv
// One DMA channel: CONFIG0..3, busy flag, start pulse and interrupt-set request.
module dma_ch_regs
  import dma_regfile_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        wr_en_i,
  input  logic [5:0]  wr_off_i,
  input  logic [31:0] wdata_i,
  input  logic        done_i,
  output logic [31:0] cfg0_o,
  output logic [31:0] cfg1_o,
  output logic [31:0] cfg2_o,
  output logic        set_int_o,
  output logic        cmd_last_o,
  output logic [27:0] next_addr_o,
  output logic        start_o,
  output logic        busy_o,
  output logic        int_set_o
);

  logic [31:0] cfg0_q, cfg0_d, cfg1_q, cfg1_d, cfg2_q, cfg2_d;
  logic [27:0] next_addr_q, next_addr_d;
  logic        set_int_q, set_int_d, cmd_last_q, cmd_last_d;
  logic        start_q, start_d, busy_q, busy_d;

  always_comb begin
    cfg0_d      = cfg0_q;
    cfg1_d      = cfg1_q;
    cfg2_d      = cfg2_q;
    next_addr_d = next_addr_q;
    set_int_d   = set_int_q;
    cmd_last_d  = cmd_last_q;
    start_d     = 1'b0;
    busy_d      = busy_q;
    // done only matters for a channel that is actually running
    if (done_i && busy_q) busy_d = 1'b0;
    if (wr_en_i) begin
      case (wr_off_i)
        OFF_CONFIG0: cfg0_d = wdata_i;
        OFF_CONFIG1: cfg1_d = wdata_i;
        OFF_CONFIG2: cfg2_d = wdata_i;
        OFF_CONFIG3: begin
          set_int_d   = wdata_i[0];
          cmd_last_d  = wdata_i[1];
          next_addr_d = wdata_i[31:4];
        end
        OFF_START: if (wdata_i[0]) begin
          start_d = 1'b1;
          busy_d  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cfg0_q      <= '0;
      cfg1_q      <= '0;
      cfg2_q      <= '0;
      next_addr_q <= '0;
      set_int_q   <= 1'b0;
      cmd_last_q  <= 1'b1;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      cfg0_q      <= cfg0_d;
      cfg1_q      <= cfg1_d;
      cfg2_q      <= cfg2_d;
      next_addr_q <= next_addr_d;
      set_int_q   <= set_int_d;
      cmd_last_q  <= cmd_last_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
    end
  end

  assign cfg0_o      = cfg0_q;
  assign cfg1_o      = cfg1_q;
  assign cfg2_o      = cfg2_q;
  assign next_addr_o = next_addr_q;
  assign set_int_o   = set_int_q;
  assign cmd_last_o  = cmd_last_q;
  assign start_o     = start_q;
  assign busy_o      = busy_q;
  assign int_set_o   = done_i & busy_q & set_int_q;

endmodule

// File: rtl/dma_regfile_mc.sv
// APB front end for NUM_CH DMA channels: wait-state FSM, decode, read mux,
// global interrupt status/enable and irq.
module dma_regfile_mc
  import dma_regfile_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ADDR_BITS   = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   pclken_i,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [ADDR_BITS-1:0]   paddr_i,
  input  logic [31:0]            pwdata_i,
  output logic [31:0]            prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  input  logic [NUM_CH-1:0]      ch_done_i,
  input  logic [NUM_CH*16-1:0]   buffer_count_i,
  input  logic [NUM_CH*16-1:0]   int_count_i,
  output logic [NUM_CH*32-1:0]   rd_start_addr_o,
  output logic [NUM_CH*32-1:0]   wr_start_addr_o,
  output logic [NUM_CH*32-1:0]   buffer_size_o,
  output logic [NUM_CH-1:0]      set_int_o,
  output logic [NUM_CH-1:0]      cmd_last_o,
  output logic [NUM_CH*28-1:0]   next_addr_o,
  output logic [NUM_CH-1:0]      ch_start_o,
  output logic [NUM_CH-1:0]      ch_busy_o,
  output logic                   irq_o
);

  localparam int CH_LSB = $clog2(CH_STRIDE);

  logic [NUM_CH-1:0][31:0] cfg0, cfg1, cfg2;
  logic [NUM_CH-1:0][27:0] nxt;
  logic [NUM_CH-1:0]       set_int, cmd_last, start, busy, int_set, ch_wr;

  apb_state_t       state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             load_rsp, pready, commit, wr_en;
  logic [31:0]      rdata_q, rdata_d;
  logic             pslverr_q, err_d;
  logic [NUM_CH-1:0] int_status_q, int_status_d, int_enable_q, int_enable_d, w1c;
  logic             irq_q;

  // decode
  logic [2:0]  ch;
  logic [5:0]  ch_off;
  logic [7:0]  g_off;
  logic        is_glob, dec_err;
  logic [31:0] s_cfg0, s_cfg1, s_cfg2, s_cfg3, s_stat, rd_mux;
  logic        s_busy;
  logic        unused_addr;

  assign ch          = paddr_i[CH_LSB +: 3];
  assign ch_off      = paddr_i[CH_LSB-1:0];
  assign g_off       = paddr_i[7:0];
  assign is_glob     = paddr_i[GLOBAL_BIT];
  assign unused_addr = ^paddr_i[10:9];
  assign dec_err     = (paddr_i[1:0] != 2'b00) || (|paddr_i[ADDR_BITS-1:12]) ||
                       (!is_glob && ({29'd0, ch} >= 32'(NUM_CH)));

  always_comb begin
    s_cfg0 = '0;
    s_cfg1 = '0;
    s_cfg2 = '0;
    s_cfg3 = '0;
    s_stat = '0;
    s_busy = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch == 3'(c)) begin
        s_cfg0 = cfg0[c];
        s_cfg1 = cfg1[c];
        s_cfg2 = cfg2[c];
        s_cfg3 = {nxt[c], 2'b00, cmd_last[c], set_int[c]};
        s_stat = {int_count_i[16*c +: 16], buffer_count_i[16*c +: 16]};
        s_busy = busy[c];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    err_d  = dec_err;
    if (!dec_err) begin
      if (is_glob) begin
        case (g_off)
          OFF_INT_STATUS: rd_mux = 32'(int_status_q);
          OFF_INT_ENABLE: rd_mux = 32'(int_enable_q);
          OFF_BUSY: begin
            rd_mux = 32'(busy);
            err_d  = pwrite_i;
          end
          default: ;
        endcase
      end else begin
        case (ch_off)
          OFF_CONFIG0: rd_mux = s_cfg0;
          OFF_CONFIG1: rd_mux = s_cfg1;
          OFF_CONFIG2: rd_mux = s_cfg2;
          OFF_CONFIG3: rd_mux = s_cfg3;
          OFF_START:   err_d  = !pwrite_i || (pwdata_i[0] && s_busy);
          OFF_STATUS: begin
            rd_mux = s_stat;
            err_d  = pwrite_i;
          end
          default: ;
        endcase
      end
    end
    rdata_d = (err_d || pwrite_i) ? 32'd0 : rd_mux;
  end

  // APB FSM: state register
  always_ff @(posedge clk_i) begin
    if (!reset_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // APB FSM: next state
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    load_rsp = 1'b0;
    if (pclken_i) begin
      case (state_q)
        IDLE: if (psel_i && !penable_i) begin
          if (WAIT_STATES == 0) begin
            state_d  = READY;
            load_rsp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 2'(WAIT_STATES);
          end
        end
        WAIT: begin
          if (!psel_i) state_d = IDLE;
          else if (penable_i) begin
            if (cnt_q == 2'd1) begin
              state_d  = READY;
              load_rsp = 1'b1;
            end else begin
              cnt_d = cnt_q - 2'd1;
            end
          end
        end
        READY:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // APB FSM: outputs
  always_comb begin
    pready = (state_q == READY);
    commit = pready && pclken_i && psel_i && penable_i;
    wr_en  = commit && pwrite_i && !pslverr_q;
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++)
      ch_wr[c] = wr_en && !is_glob && (ch == 3'(c));
    w1c          = (wr_en && is_glob && g_off == OFF_INT_STATUS) ? pwdata_i[NUM_CH-1:0] : '0;
    // a same-edge done wins over the clear
    int_status_d = (int_status_q & ~w1c) | int_set;
    int_enable_d = (wr_en && is_glob && g_off == OFF_INT_ENABLE) ? pwdata_i[NUM_CH-1:0]
                                                                 : int_enable_q;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_q        <= '0;
      rdata_q      <= '0;
      pslverr_q    <= 1'b0;
      int_status_q <= '0;
      int_enable_q <= '0;
      irq_q        <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      int_status_q <= int_status_d;
      int_enable_q <= int_enable_d;
      irq_q        <= |(int_status_q & int_enable_q);
      if (load_rsp) begin
        rdata_q   <= rdata_d;
        pslverr_q <= err_d;
      end
    end
  end

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dma_ch_regs u_ch (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .wr_en_i     (ch_wr[c]),
      .wr_off_i    (ch_off),
      .wdata_i     (pwdata_i),
      .done_i      (ch_done_i[c]),
      .cfg0_o      (cfg0[c]),
      .cfg1_o      (cfg1[c]),
      .cfg2_o      (cfg2[c]),
      .set_int_o   (set_int[c]),
      .cmd_last_o  (cmd_last[c]),
      .next_addr_o (nxt[c]),
      .start_o     (start[c]),
      .busy_o      (busy[c]),
      .int_set_o   (int_set[c])
    );
  end

  assign prdata_o        = pready ? rdata_q : 32'd0;
  assign pslverr_o       = pready ? pslverr_q : 1'b0;
  assign pready_o        = pready;
  assign rd_start_addr_o = cfg0;
  assign wr_start_addr_o = cfg1;
  assign buffer_size_o   = cfg2;
  assign next_addr_o     = nxt;
  assign set_int_o       = set_int;
  assign cmd_last_o      = cmd_last;
  assign ch_start_o      = start;
  assign ch_busy_o       = busy;
  assign irq_o           = irq_q;

endmodule

// File: tb/tb_dma_regfile_mc.sv
// Directed bench for dma_regfile_mc with 4 channels and 2 APB wait states.
module tb_dma_regfile_mc;

  localparam int NCH = 4;
  localparam int AW  = 16;
  localparam int WS  = 2;

  logic              clk = 1'b0;
  logic              reset, pclken, psel, penable, pwrite;
  logic [AW-1:0]     paddr;
  logic [31:0]       pwdata, prdata;
  logic              pready, pslverr;
  logic [NCH-1:0]    ch_done;
  logic [NCH*16-1:0] buffer_count, int_count;
  logic [NCH*32-1:0] rd_start_addr, wr_start_addr, buffer_size;
  logic [NCH-1:0]    set_int, cmd_last, ch_start, ch_busy;
  logic [NCH*28-1:0] next_addr;
  logic              irq;

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  dma_regfile_mc #(.NUM_CH(NCH), .ADDR_BITS(AW), .WAIT_STATES(WS)) dut (
    .clk_i(clk), .reset_i(reset), .pclken_i(pclken), .psel_i(psel), .penable_i(penable),
    .pwrite_i(pwrite), .paddr_i(paddr), .pwdata_i(pwdata), .prdata_o(prdata),
    .pready_o(pready), .pslverr_o(pslverr), .ch_done_i(ch_done),
    .buffer_count_i(buffer_count), .int_count_i(int_count),
    .rd_start_addr_o(rd_start_addr), .wr_start_addr_o(wr_start_addr),
    .buffer_size_o(buffer_size), .set_int_o(set_int), .cmd_last_o(cmd_last),
    .next_addr_o(next_addr), .ch_start_o(ch_start), .ch_busy_o(ch_busy), .irq_o(irq)
  );

  // One APB transfer; done_mask is driven into ch_done during the commit cycle.
  task automatic apb(input logic [AW-1:0] addr, input logic wr, input logic [31:0] wd,
                     input logic [NCH-1:0] done_mask,
                     output logic [31:0] rd, output logic err, output int acc);
    bit got;
    got = 0; rd = '0; err = 1'b0; acc = 0;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wd;
    @(posedge clk); #1;
    penable = 1'b1; acc = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pready) begin
        got = 1; rd = prdata; err = pslverr; ch_done = done_mask;
        break;
      end
      @(posedge clk); #1;
      acc++;
    end
    if (!got) begin
      vecs++; errs++;
      $display("FAIL apb_timeout addr=%h: no pready, required within 20 cycles", addr);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; ch_done = '0;
  endtask

  task automatic test_reset();
    logic [31:0] d; logic e; int a;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    vecs++; if ({pready, pslverr, prdata} !== 34'd0) begin errs++;
      $display("FAIL rst_apb got=%h required=0", {pready, pslverr, prdata}); end
    vecs++; if ({irq, ch_busy, ch_start} !== 9'd0) begin errs++;
      $display("FAIL rst_flags got=%h required=0", {irq, ch_busy, ch_start}); end
    vecs++; if (cmd_last !== 4'hF || set_int !== 4'h0 || rd_start_addr !== '0) begin errs++;
      $display("FAIL rst_cfg cmd_last=%h set_int=%h required F/0", cmd_last, set_int); end
    @(posedge clk); #1 reset = 1'b1;
    apb(16'h000C, 1'b0, '0, '0, d, e, a);
    vecs++; if (d !== 32'h2 || e !== 1'b0) begin errs++;
      $display("FAIL cfg3_reset got=%h err=%b required 00000002 err=0", d, e); end
    vecs++; if (a !== 3) begin errs++;
      $display("FAIL read_latency got=%0d required 3", a); end
    buffer_count = 64'h0000_0000_0000_0005;
    int_count    = 64'h0000_0000_0000_0003;
    apb(16'h0030, 1'b0, '0, '0, d, e, a);
    vecs++; if (d !== 32'h0003_0005 || e !== 1'b0) begin errs++;
      $display("FAIL status_read got=%h err=%b required 00030005 err=0", d, e); end
  endtask

  task automatic test_wait_write();
    logic [31:0] d; logic e; int a;
    apb(16'h0080, 1'b1, 32'hDEADBEEF, '0, d, e, a);
    vecs++; if (a !== 3 || e !== 1'b0) begin errs++;
      $display("FAIL wr_latency got=%0d err=%b required 3 err=0", a, e); end
    apb(16'h0080, 1'b0, '0, '0, d, e, a);
    vecs++; if (d !== 32'hDEADBEEF) begin errs++;
      $display("FAIL cfg0_readback got=%h required deadbeef", d); end
    vecs++; if (rd_start_addr !== {32'h0, 32'hDEADBEEF, 64'h0}) begin errs++;
      $display("FAIL rd_start_slices got=%h required ch2 only", rd_start_addr); end
  endtask

  task automatic test_start_done();
    logic [31:0] d; logic e; int a; bit saw;
    apb(16'h004C, 1'b1, 32'h1, '0, d, e, a);
    vecs++; if (set_int !== 4'b0010 || cmd_last !== 4'b1101) begin errs++;
      $display("FAIL cfg3_write set_int=%b cmd_last=%b required 0010/1101", set_int, cmd_last); end
    apb(16'h0060, 1'b1, 32'h1, '0, d, e, a);
    vecs++; if (e !== 1'b0) begin errs++; $display("FAIL start_ok err=%b required 0", e); end
    @(negedge clk);
    vecs++; if (ch_start !== 4'b0010) begin errs++;
      $display("FAIL start_pulse got=%b required 0010", ch_start); end
    @(negedge clk);
    vecs++; if (ch_start !== 4'b0000) begin errs++;
      $display("FAIL start_width got=%b required 0000", ch_start); end
    apb(16'h0808, 1'b0, '0, '0, d, e, a);
    vecs++; if (d !== 32'h2) begin errs++; $display("FAIL busy_read got=%h required 2", d); end
    apb(16'h0060, 1'b1, 32'h1, '0, d, e, a);
    saw = (ch_start != 0);
    @(negedge clk); saw |= (ch_start != 0);
    @(negedge clk); saw |= (ch_start != 0);
    vecs++; if (e !== 1'b1 || saw) begin errs++;
      $display("FAIL start_busy err=%b pulse=%b required err=1 pulse=0", e, saw); end
    @(posedge clk); #1 ch_done = 4'b0010;
    @(posedge clk); #1 ch_done = '0;
    @(negedge clk);
    vecs++; if (ch_busy !== 4'b0000) begin errs++;
      $display("FAIL done_busy got=%b required 0000", ch_busy); end
    apb(16'h0800, 1'b0, '0, '0, d, e, a);
    vecs++; if (d !== 32'h2 || irq !== 1'b0) begin errs++;
      $display("FAIL int_status got=%h irq=%b required 2 irq=0", d, irq); end
    apb(16'h0804, 1'b1, 32'h2, '0, d, e, a);
    @(negedge clk); @(negedge clk);
    vecs++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_enable got=%b required 1", irq); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d; logic e; int a;
    apb(16'h0800, 1'b1, 32'h2, '0, d, e, a);
    apb(16'h0800, 1'b0, '0, '0, d, e, a);
    vecs++; if (d !== 32'h0) begin errs++; $display("FAIL w1c_clear got=%h required 0", d); end
    apb(16'h0060, 1'b1, 32'h1, '0, d, e, a);
    apb(16'h0800, 1'b1, 32'h2, 4'b0010, d, e, a);
    apb(16'h0800, 1'b0, '0, '0, d, e, a);
    vecs++; if (d !== 32'h2 || ch_busy !== 4'b0000) begin errs++;
      $display("FAIL set_wins got=%h busy=%b required 2 busy=0", d, ch_busy); end
    vecs++; if (irq !== 1'b1) begin errs++; $display("FAIL irq_set got=%b required 1", irq); end
    apb(16'h0800, 1'b1, 32'h2, '0, d, e, a);
    apb(16'h0800, 1'b0, '0, '0, d, e, a);
    @(negedge clk); @(negedge clk);
    vecs++; if (d !== 32'h0 || irq !== 1'b0) begin errs++;
      $display("FAIL late_clear got=%h irq=%b required 0 irq=0", d, irq); end
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int a;
    logic [AW-1:0] addrs [6] = '{16'h0100, 16'h0002, 16'h0030, 16'h0020, 16'h0808, 16'h1000};
    logic          wrs   [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      apb(addrs[i], wrs[i], 32'hFFFF_FFFF, '0, d, e, a);
      vecs++; if (e !== 1'b1 || d !== 32'h0) begin errs++;
        $display("FAIL err_%0d addr=%h err=%b data=%h required err=1 data=0", i, addrs[i], e, d); end
    end
    apb(16'h0020, 1'b1, 32'h0, '0, d, e, a);
    vecs++; if (e !== 1'b0 || ch_busy !== 4'b0000) begin errs++;
      $display("FAIL start_noop err=%b busy=%b required 0/0000", e, ch_busy); end
    vecs++; if (rd_start_addr !== {32'h0, 32'hDEADBEEF, 64'h0} || cmd_last !== 4'b1101) begin errs++;
      $display("FAIL err_nochange rd=%h cmd_last=%b", rd_start_addr, cmd_last); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int a;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 16'h0000; pwdata = 32'h1234_5678;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    vecs++; if (pready !== 1'b0 || rd_start_addr !== '0) begin errs++;
      $display("FAIL mid_reset pready=%b rd=%h required 0/0", pready, rd_start_addr); end
    apb(16'h0000, 1'b1, 32'h0000_A5A5, '0, d, e, a);
    apb(16'h0000, 1'b0, '0, '0, d, e, a);
    vecs++; if (d !== 32'h0000_A5A5 || e !== 1'b0 || a !== 3) begin errs++;
      $display("FAIL post_reset got=%h err=%b acc=%0d required a5a5/0/3", d, e, a); end
  endtask

  initial begin
    reset = 1'b0; pclken = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; ch_done = '0; buffer_count = '0; int_count = '0;
    test_reset();
    test_wait_write();
    test_start_done();
    test_w1c_collision();
    test_errors();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
